// File: rtl/mux_8to1_sequencer.sv
// rtl/mux_8to1_sequencer.sv - valid/ready word capture and select sequencing for an 8-to-1 mux
module mux_8to1_sequencer #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter bit          MSB_FIRST    = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_flush,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_ready,
    output logic [7:0] o_mux_i,
    output logic [2:0] o_mux_sel,
    output logic       o_bit_valid,
    output logic       o_bit_strobe,
    output logic       o_bit_last,
    output logic       o_word_done
);

    localparam int unsigned    DIV_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [DIV_W-1:0] DIV_END = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     SEL_START = MSB_FIRST ? 3'd7 : 3'd0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [DIV_W-1:0] r_div_cnt;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_mux_i;
    logic [2:0]       r_mux_sel;
    logic             r_word_done;

    logic w_send;
    logic w_strobe;
    logic w_last;
    logic w_ready;
    logic w_xfer;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // flush wins over everything; a transfer (from IDLE or at bit_last) always lands in SEND
    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = S_IDLE;
        end else if (w_xfer) begin
            w_state_next = S_SEND;
        end else if (w_last) begin
            w_state_next = S_IDLE;
        end
    end

    always_comb begin
        w_send   = (r_state == S_SEND);
        w_strobe = w_send && (r_div_cnt == DIV_END);
        w_last   = w_strobe && (r_bit_cnt == 3'd7);
        w_ready  = !w_send || w_last;
        w_xfer   = i_in_valid && w_ready && !i_flush;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_mux_i     <= '0;
            r_mux_sel   <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (i_flush) begin
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
                r_mux_sel <= '0;
            end else if (w_xfer) begin
                r_mux_i   <= i_in_data;
                r_mux_sel <= SEL_START;
                r_div_cnt <= '0;
                r_bit_cnt <= '0;
            end else if (w_last) begin
                // word finished with nothing queued behind it
                r_mux_sel   <= '0;
                r_div_cnt   <= '0;
                r_bit_cnt   <= '0;
                r_word_done <= 1'b1;
            end else if (w_strobe) begin
                r_div_cnt <= '0;
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_mux_sel <= MSB_FIRST ? (r_mux_sel - 3'd1) : (r_mux_sel + 3'd1);
            end else if (w_send) begin
                r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
        end
    end

    assign o_in_ready   = w_ready;
    assign o_mux_i      = r_mux_i;
    assign o_mux_sel    = r_mux_sel;
    assign o_bit_valid  = w_send;
    assign o_bit_strobe = w_strobe;
    assign o_bit_last   = w_last;
    assign o_word_done  = r_word_done;

endmodule

// File: tb/tb_mux_8to1_sequencer.sv
// tb/tb_mux_8to1_sequencer.sv - scoreboard bench over three parameterisations of mux_8to1_sequencer
module tb_mux_8to1_sequencer;

    logic clk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    task automatic chk(input int inst, input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL inst%0d %s: got %0d expected %0d at %0t", inst, nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int         C  = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam bit         MSB = (g == 1);
        localparam logic [7:0] SW = (g == 0) ? 8'hA5 : ((g == 1) ? 8'h81 : 8'h3C);

        logic       rst = 1'b1;
        logic       flush = 1'b0;
        logic       in_valid = 1'b0;
        logic [7:0] in_data = 8'h00;
        logic       in_ready;
        logic [7:0] mux_i;
        logic [2:0] mux_sel;
        logic       bit_valid, bit_strobe, bit_last, word_done;
        logic       done = 1'b0;

        mux_8to1_sequencer #(.CLKS_PER_BIT(C), .MSB_FIRST(MSB)) u_dut (
            .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid),
            .i_in_data(in_data), .o_in_ready(in_ready), .o_mux_i(mux_i),
            .o_mux_sel(mux_sel), .o_bit_valid(bit_valid), .o_bit_strobe(bit_strobe),
            .o_bit_last(bit_last), .o_word_done(word_done)
        );

        // expected serial stream: {last, y, sel} per bit, pushed when a word is accepted
        logic [4:0] sb[$];
        bit         busy = 1'b0;
        int         cyc = 0;
        logic [7:0] exp_i = 8'h00;
        bit         done_exp = 1'b0;
        bit         xfer;
        logic       y;
        logic [4:0] e;

        always @(negedge clk) begin
            y = mux_i[mux_sel];
            if (rst) begin
                busy = 1'b0; cyc = 0; exp_i = 8'h00; done_exp = 1'b0;
                sb.delete();
                chk(g, "rst_bit_valid", bit_valid, 0);
                chk(g, "rst_in_ready", in_ready, 1);
                chk(g, "rst_mux_sel", mux_sel, 0);
                chk(g, "rst_mux_i", mux_i, 0);
                chk(g, "rst_word_done", word_done, 0);
                chk(g, "rst_bit_strobe", bit_strobe, 0);
            end else begin
                chk(g, "bit_valid", bit_valid, busy);
                chk(g, "in_ready", in_ready, !busy || cyc == 8*C-1);
                chk(g, "word_done", word_done, done_exp);
                chk(g, "mux_i", mux_i, exp_i);
                chk(g, "bit_strobe", bit_strobe, busy && (cyc % C) == C-1);
                chk(g, "bit_last", bit_last, busy && cyc == 8*C-1);
                chk(g, "mux_sel", mux_sel, !busy ? 0 : (MSB ? 7 - cyc/C : cyc/C));
                if (bit_strobe) begin
                    if (sb.size() == 0) begin
                        chk(g, "strobe_unexpected", bit_strobe, 0);
                    end else begin
                        e = sb.pop_front();
                        chk(g, "y", y, e[3]);
                        chk(g, "strobe_sel", mux_sel, e[2:0]);
                        chk(g, "strobe_last", bit_last, e[4]);
                    end
                end
                xfer     = in_valid && (!busy || cyc == 8*C-1) && !flush;
                done_exp = busy && cyc == 8*C-1 && !xfer && !flush;
                if (flush) begin
                    busy = 1'b0; cyc = 0;
                    sb.delete();
                end else if (xfer) begin
                    busy = 1'b1; cyc = 0; exp_i = in_data;
                    for (int k = 0; k < 8; k++) begin
                        int s;
                        s = MSB ? 7 - k : k;
                        sb.push_back({k == 7, in_data[s], 3'(s)});
                    end
                end else if (busy) begin
                    if (cyc == 8*C-1) busy = 1'b0;
                    else cyc++;
                end
            end
        end

        task automatic step(input int n);
            repeat (n) @(posedge clk);
            #1;
        endtask

        task automatic send(input logic [7:0] w);
            bit ok;
            ok = 1'b0;
            in_valid = 1'b1;
            in_data  = w;
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                ok = in_ready && !flush && !rst;
            end
            if (!ok) chk(g, "handshake_timeout", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        endtask

        initial begin
            step(3);
            rst = 1'b0;
            step(2);
            send(SW);
            step(8*C + 3);
            send(8'h0F);
            send(8'hF0);
            step(8*C + 3);
            send(8'h5A);
            step(3*C);
            flush = 1'b1;
            step(1);
            flush = 1'b0;
            step(2);
            send(8'h3C);
            step(8*C + 2);
            send(8'hC3);
            step(8*C - 1);
            flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
            step(1);
            flush = 1'b0; in_valid = 1'b0;
            step(3);
            send(8'hE7);
            step(3);
            #1;
            rst = 1'b1;
            #1;
            chk(g, "async_mux_sel", mux_sel, 0);
            chk(g, "async_mux_i", mux_i, 0);
            chk(g, "async_bit_valid", bit_valid, 0);
            chk(g, "async_in_ready", in_ready, 1);
            in_valid = 1'b1; in_data = 8'h11;
            step(2);
            in_valid = 1'b0; rst = 1'b0;
            step(2);
            for (int i = 0; i < 40; i++) begin
                send(8'($urandom));
                if ($urandom_range(0, 7) == 0) begin
                    step($urandom_range(0, 8*C));
                    flush = 1'b1;
                    step(1);
                    flush = 1'b0;
                end
                step($urandom_range(0, 3));
            end
            step(8*C + 4);
            chk(g, "sb_drained", sb.size(), 0);
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done) && t < 60000) begin
            @(posedge clk);
            t++;
        end
        chk(0, "all_done", g_inst[0].done && g_inst[1].done && g_inst[2].done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
